// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the ID-stage hazard/stall unit and the pipeline registers it controls.
// master = pipeline side (hazard sources, enable sinks); slave = the stall unit.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_Rt;
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             IFID_UsesRt;
    logic             BranchTaken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken,
        input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, stall_count
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, BranchTaken,
        output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector and stall/flush controller for a 5-stage MIPS pipeline.
// Freezes PC and IF/ID with ID/EX bubbles for LOAD_STALL cycles; a taken branch flushes instead.
module hazard_stall_unit #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave bus
);
    typedef enum logic {
        RUN,
        STALL
    } state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    state_t           state, state_next;
    logic [2:0]       cnt, cnt_next;
    logic [CNT_W-1:0] stall_count;
    logic             hazard;
    logic             pc_write, ifid_write, bubble, ifid_flush, idex_flush;

    // Loads targeting $0 never stall: $0 reads as zero regardless of the load.
    assign hazard = bus.IDEX_MemRead && (bus.IDEX_Rt != 5'd0) &&
                    ((bus.IDEX_Rt == bus.IFID_Rs) ||
                     (bus.IFID_UsesRt && (bus.IDEX_Rt == bus.IFID_Rt)));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        cnt_next   = cnt;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (rst) begin
            state_next = RUN;
            cnt_next   = 3'd0;
        end else if (bus.BranchTaken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = RUN;
            cnt_next   = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        bubble = 1'b1;
                        // A single-cycle stall needs no STALL state: the bubble clears MemRead.
                        if (LOAD_STALL > 1) begin
                            state_next = STALL;
                            cnt_next   = STALL_INIT;
                        end
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                STALL: begin
                    bubble   = 1'b1;
                    cnt_next = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            state       <= RUN;
            cnt         <= 3'd0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IFIDWrite   = ifid_write;
    assign bus.IDEX_Bubble = bubble;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Flush  = idex_flush;
    assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: single-cycle table on LOAD_STALL=1, multi-cycle
// sequences on LOAD_STALL=3, and counter saturation on CNT_W=2.
module tb_hazard_stall_unit;
    typedef struct packed {
        logic       mr;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [4:0] exp;
    } vec_t;

    // Control vector order: {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush}
    localparam logic [4:0] RUNV   = 5'b11000;
    localparam logic [4:0] STALLV = 5'b00100;
    localparam logic [4:0] BRV    = 5'b11011;
    localparam logic [4:0] RSTV   = 5'b00000;
    localparam in_t        IDLE   = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    localparam in_t        HAZ    = '{1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0};
    localparam in_t        BR     = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(16)) a_if ();
    hazard_stall_unit_if #(.CNT_W(16)) b_if ();
    hazard_stall_unit_if #(.CNT_W(2))  c_if ();

    hazard_stall_unit #(.LOAD_STALL(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    hazard_stall_unit #(.LOAD_STALL(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));
    hazard_stall_unit #(.LOAD_STALL(1), .CNT_W(2))  dut_c (.clk(clk), .rst(rst_c), .bus(c_if.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_a();
        return {a_if.PCWrite, a_if.IFIDWrite, a_if.IDEX_Bubble, a_if.IFID_Flush, a_if.IDEX_Flush};
    endfunction

    function automatic logic [4:0] ctrl_b();
        return {b_if.PCWrite, b_if.IFIDWrite, b_if.IDEX_Bubble, b_if.IFID_Flush, b_if.IDEX_Flush};
    endfunction

    function automatic logic [4:0] ctrl_c();
        return {c_if.PCWrite, c_if.IFIDWrite, c_if.IDEX_Bubble, c_if.IFID_Flush, c_if.IDEX_Flush};
    endfunction

    task automatic drive_a(input in_t v);
        a_if.IDEX_MemRead = v.mr;
        a_if.IDEX_Rt      = v.idex_rt;
        a_if.IFID_Rs      = v.rs;
        a_if.IFID_Rt      = v.rt;
        a_if.IFID_UsesRt  = v.uses;
        a_if.BranchTaken  = v.br;
    endtask

    task automatic drive_b(input in_t v);
        b_if.IDEX_MemRead = v.mr;
        b_if.IDEX_Rt      = v.idex_rt;
        b_if.IFID_Rs      = v.rs;
        b_if.IFID_Rt      = v.rt;
        b_if.IFID_UsesRt  = v.uses;
        b_if.BranchTaken  = v.br;
    endtask

    task automatic drive_c(input in_t v);
        c_if.IDEX_MemRead = v.mr;
        c_if.IDEX_Rt      = v.idex_rt;
        c_if.IFID_Rs      = v.rs;
        c_if.IFID_Rt      = v.rt;
        c_if.IFID_UsesRt  = v.uses;
        c_if.BranchTaken  = v.br;
    endtask

    // One cycle on DUT B: apply inputs just after the falling edge, check outputs 1 ns later.
    task automatic step_b(input string name, input in_t v, input logic [4:0] exp);
        @(negedge clk);
        drive_b(v);
        #1;
        check(name, 32'(ctrl_b()), 32'(exp));
    endtask

    initial begin
        vec_t tbl[13];
        int   exp_a;

        tbl = '{
            '{'{1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0}, RUNV},   // no load in EX
            '{'{1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0}, STALLV}, // lw $2; add $3,$2,$4
            '{'{1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0}, RUNV},   // bubble cleared MemRead
            '{'{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0}, RUNV},   // Rt match, Rt unused
            '{'{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0}, STALLV}, // Rt match, Rt used
            '{'{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}, RUNV},   // load to $0, Rs=$0
            '{'{1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0}, RUNV},   // load to $0, Rt=$0 used
            '{'{1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1}, BRV},    // branch beats hazard
            '{'{1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0}, STALLV}, // back-to-back pair 1
            '{'{1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0}, STALLV}, // back-to-back pair 2
            '{'{1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0}, STALLV}, // Rt-only match
            '{'{1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b0}, RUNV},   // no register match
            '{'{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1}, BRV}     // plain taken branch
        };

        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        drive_a(IDLE);
        drive_b(IDLE);
        drive_c(IDLE);

        // Reset state: enables held low and counters cleared while rst is high.
        #12;
        check("rst_ctrl_a", 32'(ctrl_a()), 32'(RSTV));
        check("rst_ctrl_b", 32'(ctrl_b()), 32'(RSTV));
        check("rst_ctrl_c", 32'(ctrl_c()), 32'(RSTV));
        check("rst_cnt_a", 32'(a_if.stall_count), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Table vectors on LOAD_STALL=1; the bench tracks the expected stall count itself.
        exp_a = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("a_cnt_%0d", i), 32'(a_if.stall_count), 32'(exp_a));
            drive_a(tbl[i].in);
            #1;
            check($sformatf("a_ctrl_%0d", i), 32'(ctrl_a()), 32'(tbl[i].exp));
            if (!tbl[i].exp[4]) exp_a++;
        end
        @(negedge clk);
        check("a_cnt_final", 32'(a_if.stall_count), 32'd5);

        // LOAD_STALL=3: hazard then MemRead dropped -> exactly three stall cycles.
        step_b("b_len_1", HAZ, STALLV);
        step_b("b_len_2", IDLE, STALLV);
        step_b("b_len_3", IDLE, STALLV);
        step_b("b_len_run", IDLE, RUNV);
        check("b_len_cnt", 32'(b_if.stall_count), 32'd3);

        // Branch taken in the second stall cycle abandons the stall.
        step_b("b_br_1", HAZ, STALLV);
        step_b("b_br_2", BR, BRV);
        step_b("b_br_run1", IDLE, RUNV);
        step_b("b_br_run2", IDLE, RUNV);
        check("b_br_cnt", 32'(b_if.stall_count), 32'd4);

        // Async reset in the second stall cycle.
        step_b("b_rst_1", HAZ, STALLV);
        step_b("b_rst_2", IDLE, STALLV);
        #1 rst_b = 1'b1;
        #1;
        check("b_rst_ctrl", 32'(ctrl_b()), 32'(RSTV));
        check("b_rst_cnt", 32'(b_if.stall_count), 32'd0);
        @(posedge clk);
        #2 rst_b = 1'b0;
        step_b("b_rel_run1", IDLE, RUNV);
        step_b("b_rel_run2", IDLE, RUNV);
        check("b_rel_cnt", 32'(b_if.stall_count), 32'd0);

        // CNT_W=2: five stall cycles saturate the counter at 3.
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("c_cnt_%0d", k), 32'(c_if.stall_count), 32'((k < 3) ? k : 3));
            drive_c((k < 5) ? HAZ : IDLE);
            #1;
            check($sformatf("c_ctrl_%0d", k), 32'(ctrl_c()), 32'((k < 5) ? STALLV : RUNV));
        end
        @(negedge clk);
        check("c_cnt_hold", 32'(c_if.stall_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
